// File: rtl/gpio_freq_meter.sv
// gpio_freq_meter: synchronizes an asynchronous GPIO input, strobes on its
// rising edges, and reports how many rising edges fell in each fixed gate
// window.
// Optional feature macro: GPIO_FREQ_METER_PERIOD_EN adds a measurement of
// the clock count between consecutive rising edges. Without it, period and
// period_valid are tied to 0.
// `edge` is a reserved word in SystemVerilog, so the rising-edge strobe
// port is called edge_pulse.
module gpio_freq_meter #(
    parameter int GATE_CYCLES = 1024,
    parameter int CNT_W       = 16,
    parameter int PER_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pin,
    output logic             level,
    output logic             edge_pulse,
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_valid,
    output logic [PER_W-1:0] period,
    output logic             period_valid
);

    localparam int                GATE_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    // Saturating increment of the edge accumulator; inc carries the edge strobe.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] a,
                                                     input logic             inc);
        if (inc && (a != CNT_MAX)) begin
            return a + CNT_W'(1);
        end
        return a;
    endfunction

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   level_d;
    logic [GATE_W-1:0]      gate_cnt;
    logic                   terminal;
    logic [CNT_W-1:0]       acc;

    // --- stage: metastability chain, pin enters at bit 0 ---
    // Shift the raw pin through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], pin};
        end
    end

    assign level = sync_p[SYNC_STAGES-1];

    // --- stage: one-cycle delayed level for edge decode ---
    // Keep the previous synchronized level so the edge is decoded from flops only.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign edge_pulse = level & ~level_d;

    // Gate window counter: 0..GATE_CYCLES-1, wrapping on the terminal cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt <= '0;
        end else if (terminal) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
        end
    end

    assign terminal = (gate_cnt == GATE_LAST);

    // --- stage: window result register ---
    // Accumulate edges; on the terminal cycle publish the total, including an
    // edge arriving in that same cycle, and start the next window from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            freq_count <= '0;
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= terminal;
            if (terminal) begin
                freq_count <= cnt_sat_inc(acc, edge_pulse);
                acc        <= '0;
            end else begin
                acc        <= cnt_sat_inc(acc, edge_pulse);
            end
        end
    end

`ifdef GPIO_FREQ_METER_PERIOD_EN
    localparam logic [PER_W-1:0] PER_MAX = '1;

    // Saturating +1 for the interval counter; all ones means "too slow".
    function automatic logic [PER_W-1:0] per_sat_inc(input logic [PER_W-1:0] a);
        if (a != PER_MAX) begin
            return a + PER_W'(1);
        end
        return a;
    endfunction

    logic [PER_W-1:0] per_cnt;
    logic             armed;

    // --- stage: period result register ---
    // Count clocks since the last edge; an edge restarts the count at 1 so
    // that per_cnt equals the interval when the next edge arrives. The first
    // edge after reset only arms the measurement.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt      <= '0;
            armed        <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= edge_pulse & armed;
            if (edge_pulse) begin
                per_cnt <= PER_W'(1);
                armed   <= 1'b1;
                if (armed) begin
                    period <= per_cnt;
                end
            end else begin
                per_cnt <= per_sat_inc(per_cnt);
            end
        end
    end
`else
    assign period       = '0;
    assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_freq_meter.sv
// Testbench for gpio_freq_meter: four parameterizations share pin and rst;
// a scenario table selects which instance is observed, a cycle model predicts
// level/edge, and expected window counts and periods flow through queues.
module tb_gpio_freq_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic pin = 1'b0;

  logic        level_a, edge_a, fv_a, pv_a;
  logic [15:0] fc_a, per_a;
  logic        level_b, edge_b, fv_b, pv_b;
  logic [15:0] fc_b, per_b;
  logic        level_c, edge_c, fv_c, pv_c;
  logic [2:0]  fc_c;
  logic [3:0]  per_c;
  logic        level_d, edge_d, fv_d, pv_d;
  logic [15:0] fc_d, per_d;

  gpio_freq_meter #(.GATE_CYCLES(64), .CNT_W(16), .PER_W(16), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst(rst), .pin(pin), .level(level_a), .edge_pulse(edge_a),
    .freq_count(fc_a), .freq_valid(fv_a), .period(per_a), .period_valid(pv_a));

  gpio_freq_meter #(.GATE_CYCLES(16), .CNT_W(16), .PER_W(16), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst(rst), .pin(pin), .level(level_b), .edge_pulse(edge_b),
    .freq_count(fc_b), .freq_valid(fv_b), .period(per_b), .period_valid(pv_b));

  gpio_freq_meter #(.GATE_CYCLES(64), .CNT_W(3), .PER_W(4), .SYNC_STAGES(2)) u_c (
    .clk(clk), .rst(rst), .pin(pin), .level(level_c), .edge_pulse(edge_c),
    .freq_count(fc_c), .freq_valid(fv_c), .period(per_c), .period_valid(pv_c));

  gpio_freq_meter #(.GATE_CYCLES(16), .CNT_W(16), .PER_W(16), .SYNC_STAGES(3)) u_d (
    .clk(clk), .rst(rst), .pin(pin), .level(level_d), .edge_pulse(edge_d),
    .freq_count(fc_d), .freq_valid(fv_d), .period(per_d), .period_valid(pv_d));

  // Observed instance, widened to a common shape.
  int          sel = 0;
  logic        m_level, m_edge, m_fv, m_pv;
  logic [31:0] m_fc, m_per;

  always_comb begin
    m_level = 1'b0; m_edge = 1'b0; m_fv = 1'b0; m_pv = 1'b0;
    m_fc = '0; m_per = '0;
    case (sel)
      0: begin m_level = level_a; m_edge = edge_a; m_fv = fv_a; m_pv = pv_a;
               m_fc = 32'(fc_a); m_per = 32'(per_a); end
      1: begin m_level = level_b; m_edge = edge_b; m_fv = fv_b; m_pv = pv_b;
               m_fc = 32'(fc_b); m_per = 32'(per_b); end
      2: begin m_level = level_c; m_edge = edge_c; m_fv = fv_c; m_pv = pv_c;
               m_fc = 32'(fc_c); m_per = 32'(per_c); end
      default: begin m_level = level_d; m_edge = edge_d; m_fv = fv_d; m_pv = pv_d;
               m_fc = 32'(fc_d); m_per = 32'(per_d); end
    endcase
  end

  // exp_w0 / exp_wn: expected count of the first / later windows;
  // -1 = not checked, -2 = taken from the edge model.
  typedef struct {
    int sel; int kind; int ncyc; int rst_at; int gate; int sync;
    int cnt_max; int per_max; int exp_w0; int exp_wn;
  } scn_t;

  scn_t scns[5];
  int   n_vec = 0;
  int   n_err = 0;
  int   cur_scn = -1;
  int   cur_m = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s scn=%0d cycle=%0d got=%0d expected=%0d", name, cur_scn, cur_m, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic pin_fn(input int kind, input int g);
    case (kind)
      1: return (((g % 8) + 8) % 8) < 4;
      2: return g >= 13;
      3: return (((g % 4) + 4) % 4) < 2;
      4: return (((g % 40) + 40) % 40) < 20;
      default: return ((g >= 5) && (g < 20)) || (g >= 30);
    endcase
  endfunction

  task automatic run_scn(input int idx);
    scn_t        s;
    bit          hist [0:2047];
    int          m, acc, last, win, w;
    bit          armed, exp_pv, fc_known, rst_now, exp_level, prev, exp_edge, exp_fv;
    logic [31:0] exp_fc, exp_per;
    int          fq[$];
    int          pq[$];
    s = scns[idx];
    cur_scn = idx;
    sel = s.sel;
    m = 0; acc = 0; last = 0; win = 0; armed = 0; exp_pv = 0;
    fc_known = 1; exp_fc = '0; exp_per = '0;
    for (int g = -5; g < s.ncyc; g++) begin
      if (g >= 0) begin
        cur_m = m;
        exp_level = (m >= s.sync) ? hist[m - s.sync] : 1'b0;
        prev      = (m >= s.sync + 1) ? hist[m - s.sync - 1] : 1'b0;
        exp_edge  = exp_level & ~prev;
        chk("level", 32'(m_level), 32'(exp_level));
        chk("edge", 32'(m_edge), 32'(exp_edge));
        exp_fv = (m > 0) && (m % s.gate == 0);
        chk("freq_valid", 32'(m_fv), 32'(exp_fv));
        if (exp_fv) begin
          if (fq.size() > 0) begin
            w = fq.pop_front();
            fc_known = (w >= 0);
            exp_fc = w;
          end else begin
            fc_known = 0;
          end
        end
        if (fc_known) chk("freq_count", m_fc, exp_fc);
`ifdef GPIO_FREQ_METER_PERIOD_EN
        chk("period_valid", 32'(m_pv), 32'(exp_pv));
        if (exp_pv && pq.size() > 0) exp_per = pq.pop_front();
        chk("period", m_per, exp_per);
`else
        chk("period_valid", 32'(m_pv), 32'd0);
        chk("period", m_per, 32'd0);
`endif
        // Model update for this cycle; results land next cycle.
        acc = imin(acc + int'(exp_edge), s.cnt_max);
        if (m % s.gate == s.gate - 1) begin
          w = (win == 0) ? s.exp_w0 : s.exp_wn;
          if (w == -2) w = acc;
          fq.push_back(w);
          acc = 0;
          win++;
        end
        exp_pv = 0;
        if (exp_edge) begin
          if (armed) begin
            pq.push_back(imin(m - last, s.per_max));
            exp_pv = 1;
          end
          armed = 1;
          last = m;
        end
      end
      rst_now = (g < 0) || (g == s.rst_at);
      rst = rst_now;
      pin = pin_fn(s.kind, g);
      if (rst_now) begin
        m = 0; acc = 0; win = 0; armed = 0; exp_pv = 0;
        fc_known = 1; exp_fc = '0; exp_per = '0;
        fq.delete();
        pq.delete();
      end else begin
        hist[m] = pin;
        m++;
      end
      tick();
    end
  endtask

  initial begin
    scns[0] = '{0, 1, 420, 286, 64, 2, 65535, 65535, -1, 8};
    scns[1] = '{1, 2, 50, -100, 16, 2, 65535, 65535, 1, 0};
    scns[2] = '{2, 3, 200, -100, 64, 2, 7, 15, 7, 7};
    scns[3] = '{2, 4, 300, -100, 64, 2, 7, 15, -2, -2};
    scns[4] = '{3, 5, 60, -100, 16, 3, 65535, 65535, -2, -2};

    for (int i = 0; i < 5; i++) begin
      run_scn(i);
    end

    // Pin held high through reset: outputs stay cleared, then exactly one
    // edge appears SYNC_STAGES cycles after release.
    cur_scn = 9;
    sel = 0;
    rst = 1'b1;
    pin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cur_m = -3 + i;
      chk("rst_level", 32'(m_level), 32'd0);
      chk("rst_freq_count", m_fc, 32'd0);
      chk("rst_freq_valid", 32'(m_fv), 32'd0);
    end
    rst = 1'b0;
    cur_m = 0;
    chk("c0_edge", 32'(m_edge), 32'd0);
    tick();
    cur_m = 1;
    chk("c1_level", 32'(m_level), 32'd0);
    tick();
    cur_m = 2;
    chk("c2_level", 32'(m_level), 32'd1);
    chk("c2_edge", 32'(m_edge), 32'd1);
    tick();
    cur_m = 3;
    chk("c3_edge", 32'(m_edge), 32'd0);
    chk("c3_level", 32'(m_level), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
